// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding control unit.
// Holds the scoreboard entry layout, the halt-drain FSM states and the
// regfile forward-select encoding.
package pipe_hazard_pkg;

  localparam int unsigned SB_REG_ADDR_W = 5;
  localparam int unsigned SB_NUM_SRC    = 2;
  localparam int unsigned FSEL_REGFILE  = 0;

  // One in-flight instruction as seen by the hazard unit
  typedef struct packed {
    logic                                     valid;
    logic [SB_REG_ADDR_W-1:0]                 rd;
    logic                                     regwrite;
    logic                                     memread;
    logic                                     multicycle;
    logic [SB_NUM_SRC-1:0][SB_REG_ADDR_W-1:0] rs;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
// master drives the ID instruction description, ex_redirect and ex_halt;
// slave returns PC/IF/ID/EX controls, forward selects, halted and statistics.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned CNT_W      = 32
);
  localparam int unsigned FSEL_W = $clog2(FWD_DEPTH + 1);

  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]            id_rs_used;
  logic [REG_ADDR_W-1:0]         id_rd;
  logic                          id_regwrite;
  logic                          id_memread;
  logic                          id_multicycle;
  logic                          ex_redirect;
  logic                          ex_halt;
  logic                          pc_stall;
  logic                          ifid_stall;
  logic                          ifid_flush;
  logic                          idex_bubble;
  logic                          ex_hold;
  logic [NUM_SRC*FSEL_W-1:0]     fwd_sel;
  logic                          halted;
  logic [CNT_W-1:0]              stat_stall;
  logic [CNT_W-1:0]              stat_flush;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread,
           id_multicycle, ex_redirect, ex_halt,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold, fwd_sel,
           halted, stat_stall, stat_flush
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread,
           id_multicycle, ex_redirect, ex_halt,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold, fwd_sel,
           halted, stat_stall, stat_flush
  );

endinterface

// File: rtl/hz_src_match.sv
// Per-source priority matcher over the hazard scoreboard.
// Ports: sb_i scoreboard (position 0 = EX), rs_i/used_i source register,
//        fwd_sel_o youngest usable forwarding position (0 = regfile),
//        load_hit_o youngest match is a load too young to forward.
// FIRST_POS is the youngest position searched; LOAD_LAG is how many cycles
// later the consumer reaches EX (0 for an EX source, 1 for an ID source).
module hz_src_match
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned FWD_DEPTH      = 2,
  parameter int unsigned LOAD_FWD_STAGE = 2,
  parameter int unsigned FIRST_POS      = 1,
  parameter int unsigned LOAD_LAG       = 0
) (
  input  sb_entry_t [FWD_DEPTH:0]   sb_i,
  input  logic [SB_REG_ADDR_W-1:0]  rs_i,
  input  logic                      used_i,
  output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_sel_o,
  output logic                      load_hit_o
);
  localparam int unsigned FSEL_W = $clog2(FWD_DEPTH + 1);

  logic              hit_c;
  logic              hit_load_c;
  logic              too_young_c;
  logic [FSEL_W-1:0] hit_pos_c;
  logic              unused_sb_c;

  // Scan oldest to youngest so the youngest match wins
  always_comb begin
    hit_c      = 1'b0;
    hit_load_c = 1'b0;
    hit_pos_c  = '0;
    for (int k = int'(FWD_DEPTH); k >= int'(FIRST_POS); k--) begin
      if (used_i && (rs_i != '0) && sb_i[k].valid && sb_i[k].regwrite &&
          (sb_i[k].rd == rs_i)) begin
        hit_c      = 1'b1;
        hit_load_c = sb_i[k].memread;
        hit_pos_c  = FSEL_W'(k);
      end
    end
    too_young_c = hit_load_c &&
                  ((int'(hit_pos_c) + int'(LOAD_LAG)) < int'(LOAD_FWD_STAGE));
    fwd_sel_o   = (hit_c && !too_young_c) ? hit_pos_c : FSEL_W'(FSEL_REGFILE);
    load_hit_o  = hit_c && too_young_c;
  end

  assign unused_sb_c = ^sb_i;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and pipeline-control unit beside the ID/EX boundary.
// Ports: clk, reset (sync, active-high), hz (slave modport of
//        pipe_hazard_ctrl_if: ID instruction info, ex_redirect, ex_halt in;
//        PC/IF/ID/EX controls, fwd_sel, halted, stat_* out).
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise stat_stall/stat_flush are tied to 0.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W     = SB_REG_ADDR_W,
  parameter int unsigned NUM_SRC        = SB_NUM_SRC,
  parameter int unsigned FWD_DEPTH      = 2,
  parameter int unsigned LOAD_FWD_STAGE = 2,
  parameter int unsigned MC_LAT         = 4,
  parameter int unsigned CNT_W          = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int unsigned FSEL_W   = $clog2(FWD_DEPTH + 1);
  localparam int unsigned MC_CNT_W = $clog2(MC_LAT);

  hz_state_e                  state_q, state_d;
  sb_entry_t [FWD_DEPTH:0]    sb_q, sb_d;
  logic [MC_CNT_W-1:0]        mc_cnt_q, mc_cnt_d;
  sb_entry_t                  id_entry_c;
  logic [NUM_SRC-1:0][FSEL_W-1:0] ex_fsel_c, id_fsel_c;
  logic [NUM_SRC-1:0]         ex_load_hit_c, id_load_hit_c;
  logic ex_hold_c, ex_go_c, load_use_c, drained_c;
  logic halt_ok_c, redirect_ok_c, stall_ev_c;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_bubble_c;

  // ID instruction in scoreboard-entry form
  always_comb begin
    id_entry_c            = SB_EMPTY;
    id_entry_c.valid      = hz.id_valid;
    id_entry_c.rd         = hz.id_rd;
    id_entry_c.regwrite   = hz.id_regwrite;
    id_entry_c.memread    = hz.id_memread;
    id_entry_c.multicycle = hz.id_multicycle;
    for (int s = 0; s < int'(NUM_SRC); s++)
      id_entry_c.rs[s] = hz.id_rs[s*REG_ADDR_W +: REG_ADDR_W];
  end

  // EX sources pick forwarding; ID sources look for a load-use hazard
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hz_src_match #(
      .FWD_DEPTH(FWD_DEPTH), .LOAD_FWD_STAGE(LOAD_FWD_STAGE),
      .FIRST_POS(1), .LOAD_LAG(0)
    ) u_ex_match (
      .sb_i(sb_q), .rs_i(sb_q[0].rs[s]), .used_i(1'b1),
      .fwd_sel_o(ex_fsel_c[s]), .load_hit_o(ex_load_hit_c[s])
    );
    hz_src_match #(
      .FWD_DEPTH(FWD_DEPTH), .LOAD_FWD_STAGE(LOAD_FWD_STAGE),
      .FIRST_POS(0), .LOAD_LAG(1)
    ) u_id_match (
      .sb_i(sb_q), .rs_i(id_entry_c.rs[s]), .used_i(hz.id_rs_used[s]),
      .fwd_sel_o(id_fsel_c[s]), .load_hit_o(id_load_hit_c[s])
    );
  end

  assign ex_hold_c  = (mc_cnt_q != '0);
  assign ex_go_c    = sb_q[0].valid && !ex_hold_c;
  assign load_use_c = hz.id_valid && (|id_load_hit_c);

  always_comb begin
    drained_c = (mc_cnt_q == '0);
    for (int k = 0; k <= int'(FWD_DEPTH); k++)
      if (sb_q[k].valid) drained_c = 1'b0;
  end

  // FSM next state and pipeline controls; halt/drain > redirect > hold > load-use
  always_comb begin
    state_d       = state_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    halt_ok_c     = 1'b0;
    redirect_ok_c = 1'b0;
    stall_ev_c    = 1'b0;
    case (state_q)
      RUN: begin
        halt_ok_c     = ex_go_c && hz.ex_halt;
        redirect_ok_c = ex_go_c && hz.ex_redirect && !halt_ok_c;
        if (halt_ok_c) begin
          // Stop younger work entering EX from the HALT cycle onward
          state_d       = DRAIN;
          pc_stall_c    = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (redirect_ok_c) begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (ex_hold_c) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          stall_ev_c    = 1'b1;
        end else if (load_use_c) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idex_bubble_c = 1'b1;
          stall_ev_c    = 1'b1;
        end
      end
      DRAIN, HALTED: begin
        pc_stall_c    = 1'b1;
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        if (state_q == DRAIN && drained_c) state_d = HALTED;
      end
      default: state_d = RUN;
    endcase
  end

  // Scoreboard shift and multi-cycle occupancy counter
  always_comb begin
    sb_d = sb_q;
    for (int k = 2; k <= int'(FWD_DEPTH); k++) sb_d[k] = sb_q[k-1];
    sb_d[1]  = ex_hold_c ? SB_EMPTY : sb_q[0];
    mc_cnt_d = ex_hold_c ? mc_cnt_q - MC_CNT_W'(1) : mc_cnt_q;
    if (!ex_hold_c) begin
      sb_d[0] = idex_bubble_c ? SB_EMPTY : id_entry_c;
      if (!idex_bubble_c && hz.id_valid && hz.id_multicycle)
        mc_cnt_d = MC_CNT_W'(MC_LAT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q     <= '0;
      mc_cnt_q <= '0;
    end else begin
      sb_q     <= sb_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  assign hz.pc_stall    = pc_stall_c;
  assign hz.ifid_stall  = ifid_stall_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.idex_bubble = idex_bubble_c;
  assign hz.ex_hold     = ex_hold_c;
  assign hz.fwd_sel     = ex_fsel_c;
  assign hz.halted      = (state_q == HALTED);

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stat_stall_q, stat_flush_q;
  logic             unused_c;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_q <= '0;
      stat_flush_q <= '0;
    end else begin
      if (stall_ev_c && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + CNT_W'(1);
      if (redirect_ok_c && (stat_flush_q != '1))
        stat_flush_q <= stat_flush_q + CNT_W'(1);
    end
  end

  assign hz.stat_stall = stat_stall_q;
  assign hz.stat_flush = stat_flush_q;
  assign unused_c      = ^{ex_load_hit_c, id_fsel_c};
`else
  logic unused_c;
  assign hz.stat_stall = '0;
  assign hz.stat_flush = '0;
  assign unused_c      = ^{ex_load_hit_c, id_fsel_c, stall_ev_c};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters
// (FWD_DEPTH=2, LOAD_FWD_STAGE=2, MC_LAT=4). Inputs change 2ns after the
// rising edge and outputs are sampled 1ns later.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;
  logic [31:0] s0, f0;
  logic [4:0]  ctrl;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .hz   (bus)
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold}
  assign ctrl = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_bubble, bus.ex_hold};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mc);
    bus.id_valid      = v;
    bus.id_rs         = {rs1, rs0};
    bus.id_rs_used    = used;
    bus.id_rd         = rd;
    bus.id_regwrite   = rw;
    bus.id_memread    = mr;
    bus.id_multicycle = mc;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ex_redirect = 1'b0;
    bus.ex_halt     = 1'b0;
    set_id(1'b1, 5'd3, 5'd4, 2'b11, 5'd7, 1'b1, 1'b1, 1'b1);
    step();
    step();
    reset = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_vec++; if (ctrl !== 5'b00000) begin n_miss++; $display("FAIL reset_ctrl got %b want 00000", ctrl); end
    n_vec++; if (bus.fwd_sel !== 4'b0000) begin n_miss++; $display("FAIL reset_fwd got %b want 0000", bus.fwd_sel); end
    n_vec++; if (bus.halted !== 1'b0) begin n_miss++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    n_vec++; if ({bus.stat_stall, bus.stat_flush} !== 64'd0) begin n_miss++; $display("FAIL reset_stats got %0d/%0d want 0/0", bus.stat_stall, bus.stat_flush); end
  endtask

  // add x5 then two consumers of x5: select 1 then 2; youngest writer wins
  task automatic test_forward();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd5, 5'd3, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
    settle();
    n_vec++; if (ctrl !== 5'b00000) begin n_miss++; $display("FAIL fwd_no_stall got %b want 00000", ctrl); end
    step();
    set_id(1'b1, 5'd0, 5'd5, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
    settle();
    n_vec++; if (bus.fwd_sel !== 4'b0001) begin n_miss++; $display("FAIL fwd_stage1 got %b want 0001", bus.fwd_sel); end
    step();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_vec++; if (bus.fwd_sel !== 4'b1000) begin n_miss++; $display("FAIL fwd_stage2 got %b want 1000", bus.fwd_sel); end
    idle(3);
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd15, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd15, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd1, 5'd15, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_vec++; if (bus.fwd_sel !== 4'b0100) begin n_miss++; $display("FAIL fwd_youngest got %b want 0100", bus.fwd_sel); end
    idle(3);
  endtask

  // lw x6 then consumer: one stall cycle, then forwarded from stage 2
  task automatic test_load_use();
    s0 = bus.stat_stall;
    set_id(1'b1, 5'd1, 5'd2, 2'b01, 5'd6, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd1, 5'd6, 2'b11, 5'd10, 1'b1, 1'b0, 1'b0);
    settle();
    n_vec++; if (ctrl !== 5'b11010) begin n_miss++; $display("FAIL lu_stall got %b want 11010", ctrl); end
    step();
    settle();
    n_vec++; if (ctrl !== 5'b00000) begin n_miss++; $display("FAIL lu_one_cycle got %b want 00000", ctrl); end
    step();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_vec++; if (bus.fwd_sel !== 4'b1000) begin n_miss++; $display("FAIL lu_fwd got %b want 1000", bus.fwd_sel); end
    n_vec++; if (bus.stat_stall - s0 !== (STATS ? 32'd1 : 32'd0)) begin n_miss++; $display("FAIL lu_stat got %0d want %0d", bus.stat_stall - s0, STATS ? 1 : 0); end
    idle(3);
  endtask

  // x0 destination never matches; unused source never stalls
  task automatic test_x0_and_unused();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd11, 1'b1, 1'b0, 1'b0);
    settle();
    n_vec++; if (ctrl !== 5'b00000) begin n_miss++; $display("FAIL x0_no_stall got %b want 00000", ctrl); end
    step();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_vec++; if (bus.fwd_sel !== 4'b0000) begin n_miss++; $display("FAIL x0_fwd got %b want 0000", bus.fwd_sel); end
    idle(3);
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd14, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd14, 5'd14, 2'b00, 5'd12, 1'b1, 1'b0, 1'b0);
    settle();
    n_vec++; if (ctrl !== 5'b00000) begin n_miss++; $display("FAIL unused_src got %b want 00000", ctrl); end
    idle(3);
  endtask

  // MC_LAT=4 op holds EX for 3 cycles; redirect during hold is ignored
  task automatic test_multicycle();
    s0 = bus.stat_stall;
    f0 = bus.stat_flush;
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0, 1'b1);
    step();
    set_id(1'b1, 5'd8, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.ex_redirect = (i == 1);
      settle();
      n_vec++;
      if (ctrl !== ((i < 3) ? 5'b11001 : 5'b00000)) begin
        n_miss++;
        $display("FAIL mc_hold_%0d got %b want %b", i, ctrl, (i < 3) ? 5'b11001 : 5'b00000);
      end
      bus.ex_redirect = 1'b0;
      step();
    end
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_vec++; if (bus.fwd_sel !== 4'b0001) begin n_miss++; $display("FAIL mc_fwd got %b want 0001", bus.fwd_sel); end
    n_vec++; if (bus.stat_stall - s0 !== (STATS ? 32'd3 : 32'd0)) begin n_miss++; $display("FAIL mc_stat got %0d want %0d", bus.stat_stall - s0, STATS ? 3 : 0); end
    n_vec++; if (bus.stat_flush !== f0) begin n_miss++; $display("FAIL mc_noflush got %0d want %0d", bus.stat_flush, f0); end
    idle(3);
  endtask

  // Redirect beats a coincident load-use; ignored with EX empty
  task automatic test_redirect();
    s0 = bus.stat_stall;
    f0 = bus.stat_flush;
    set_id(1'b1, 5'd1, 5'd2, 2'b01, 5'd10, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd10, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0, 1'b0);
    bus.ex_redirect = 1'b1;
    settle();
    n_vec++; if (ctrl !== 5'b00110) begin n_miss++; $display("FAIL rd_override got %b want 00110", ctrl); end
    step();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_vec++; if (ctrl !== 5'b00000) begin n_miss++; $display("FAIL rd_ex_empty got %b want 00000", ctrl); end
    bus.ex_redirect = 1'b0;
    step();
    settle();
    n_vec++; if (bus.stat_flush - f0 !== (STATS ? 32'd1 : 32'd0)) begin n_miss++; $display("FAIL rd_stat_flush got %0d want %0d", bus.stat_flush - f0, STATS ? 1 : 0); end
    n_vec++; if (bus.stat_stall !== s0) begin n_miss++; $display("FAIL rd_stat_stall got %0d want %0d", bus.stat_stall, s0); end
    idle(3);
  endtask

  // HALT behind two writers: the HALT entry itself drains to position 2,
  // so DRAIN lasts three cycles before halted rises
  task automatic test_halt();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 1'b0, 1'b0);
    bus.ex_halt = 1'b1;
    settle();
    n_vec++; if (ctrl !== 5'b10110) begin n_miss++; $display("FAIL halt_detect got %b want 10110", ctrl); end
    n_vec++; if (bus.halted !== 1'b0) begin n_miss++; $display("FAIL halt_early got %b want 0", bus.halted); end
    step();
    bus.ex_halt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      n_vec++;
      if ({bus.halted, ctrl} !== {(i >= 3), 5'b10110}) begin
        n_miss++;
        $display("FAIL halt_seq_%0d got %b/%b want %b/10110", i, bus.halted, ctrl, (i >= 3));
      end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_vec++; if ({bus.halted, ctrl} !== 6'b000000) begin n_miss++; $display("FAIL halt_reset got %b/%b want 0/00000", bus.halted, ctrl); end
    n_vec++; if ({bus.stat_stall, bus.stat_flush} !== 64'd0) begin n_miss++; $display("FAIL halt_reset_stats got %0d/%0d want 0/0", bus.stat_stall, bus.stat_flush); end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_x0_and_unused();
    test_multicycle();
    test_redirect();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
